// File: rtl/uart_rx_core_if.sv
// -----------------------------------------------------------------------------
// uart_rx_core_if
// Bundles the serial-side inputs and parallel-side outputs of uart_rx_core.
//   baud_tick_16x : 16x oversample strobe from the baud generator (to receiver)
//   rx            : asynchronous serial line, idle high (to receiver)
//   rx_data       : last received data word, LSB first on the wire (from receiver)
//   rx_valid      : one-clk pulse on a good frame (from receiver)
//   framing_error : one-clk pulse when the stop bit is sampled low (from receiver)
//   rx_busy       : receiver is not idle (from receiver)
//   parity_error  : one-clk parity mismatch pulse, only with UART_RX_PARITY_EN
// Modports: master = line/strobe source and data consumer, slave = receiver.
// -----------------------------------------------------------------------------
interface uart_rx_core_if #(
  parameter int DATA_BITS = 8
);
  logic                 baud_tick_16x;
  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 framing_error;
  logic                 rx_busy;
`ifdef UART_RX_PARITY_EN
  logic                 parity_error;
`endif

  modport master (
    output baud_tick_16x,
    output rx,
    input  rx_data,
    input  rx_valid,
    input  framing_error,
    input  rx_busy
`ifdef UART_RX_PARITY_EN
    , input parity_error
`endif
  );

  modport slave (
    input  baud_tick_16x,
    input  rx,
    output rx_data,
    output rx_valid,
    output framing_error,
    output rx_busy
`ifdef UART_RX_PARITY_EN
    , output parity_error
`endif
  );
endinterface

// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
// UART receive engine driven by a 16x oversample strobe. The rx line is
// synchronised, the start bit is validated at its midpoint, each data bit is
// sampled at mid-period and shifted in LSB first, and the stop bit is checked.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : uart_rx_core_if.slave (tick and rx in; rx_data, rx_valid,
//          framing_error, rx_busy and optional parity_error out)
// Optional feature: define UART_RX_PARITY_EN to add a parity bit between the
// data and stop bits, the ODD_PARITY parameter and the parity_error output.
// -----------------------------------------------------------------------------
module uart_rx_core #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
`ifdef UART_RX_PARITY_EN
  , parameter bit ODD_PARITY = 1'b0
`endif
) (
  input  logic         clk,
  input  logic         rst,
  uart_rx_core_if.slave bus
);

  localparam int BW = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK_WAIT
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic [3:0]             tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                   par_q, par_d;
  logic                   perr_q, perr_d;
`endif

  // Input synchroniser: idle-high reset so a reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], bus.rx};
  end

  assign rxs = sync_q[SYNC_STAGES-1];

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q      <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      ferr_q     <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q      <= par_d;
      perr_q     <= perr_d;
`endif
    end
  end

  // Next state; everything only moves on oversample ticks
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    ferr_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d      = par_q;
    perr_d     = 1'b0;
`endif
    if (bus.baud_tick_16x) begin
      case (state_q)
        IDLE: begin
          if (!rxs) begin
            state_d    = START;
            tick_cnt_d = '0;
          end
        end
        START: begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          // Eighth tick after the falling edge is the middle of the start bit
          if (tick_cnt_q == 4'd7) begin
            if (!rxs) begin
              state_d    = DATA;
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
            end else begin
              state_d = IDLE;
            end
          end
        end
        DATA: begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            shift_d    = {rxs, shift_q[DATA_BITS-1:1]};
            tick_cnt_d = '0;
            bit_cnt_d  = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            par_d      = rxs;
            tick_cnt_d = '0;
            state_d    = STOP;
          end
        end
`endif
        STOP: begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          // Leaving at the stop midpoint lets a gapless next start be caught
          if (tick_cnt_q == 4'd15) begin
            tick_cnt_d = '0;
            rx_data_d  = shift_q;
`ifdef UART_RX_PARITY_EN
            perr_d     = ((^shift_q) ^ par_q) != ODD_PARITY;
`endif
            if (rxs) begin
              rx_valid_d = 1'b1;
              state_d    = IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = BREAK_WAIT;
            end
          end
        end
        BREAK_WAIT: begin
          // A held-low line reports one framing error, then waits for idle
          if (rxs) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.rx_data       = rx_data_q;
  assign bus.rx_valid      = rx_valid_q;
  assign bus.framing_error = ferr_q;
  assign bus.rx_busy       = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign bus.parity_error  = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_core
// Directed bench for uart_rx_core: tick every 10 clks, 160 clks per bit.
// Works with and without UART_RX_PARITY_EN (even parity in that build).
// -----------------------------------------------------------------------------
module tb_uart_rx_core;

  localparam int BIT_CLKS = 160;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_CLKS = 11 * BIT_CLKS;
`else
  localparam int FRAME_CLKS = 10 * BIT_CLKS;
`endif
  // Start drive to observed valid: 3..12 clks detection + 1520 + 1 sample
  localparam int LAT_LO = FRAME_CLKS - 79;
  localparam int LAT_HI = FRAME_CLKS - 65;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  uart_rx_core_if #(.DATA_BITS(8)) bus_if ();

  uart_rx_core #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Baud generator stand-in: one-clk tick every 10 clks
  initial begin
    bus_if.baud_tick_16x = 1'b0;
    forever begin
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        bus_if.baud_tick_16x = (k == 0);
      end
    end
  end

  // Output monitor, sampled on the falling edge
  int        valid_cnt  = 0;
  int        ferr_cnt   = 0;
  int        perr_cnt   = 0;
  int        perr_coinc = 0;
  logic [7:0] vdata [16];
  int        vtime [16];

  initial begin
    forever begin
      @(negedge clk);
      if (bus_if.rx_valid === 1'b1) begin
        if (valid_cnt < 16) begin
          vdata[valid_cnt] = bus_if.rx_data;
          vtime[valid_cnt] = cyc;
        end
        valid_cnt++;
      end
      if (bus_if.framing_error === 1'b1) ferr_cnt++;
`ifdef UART_RX_PARITY_EN
      if (bus_if.parity_error === 1'b1) begin
        perr_cnt++;
        if (bus_if.rx_valid === 1'b1) perr_coinc++;
      end
`endif
    end
  end

  task automatic drive_bit(input logic b);
    bus_if.rx = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_flip);
`endif
    drive_bit(stop_bit);
  endtask

  task automatic idle(input int n);
    bus_if.rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    bus_if.rx = 1'b1;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    tests++; if (bus_if.rx_data !== 8'h00) begin fails++; $display("FAIL reset_rx_data: got %h want 00", bus_if.rx_data); end
    tests++; if (bus_if.rx_valid !== 1'b0) begin fails++; $display("FAIL reset_rx_valid: got %b want 0", bus_if.rx_valid); end
    tests++; if (bus_if.framing_error !== 1'b0) begin fails++; $display("FAIL reset_framing_error: got %b want 0", bus_if.framing_error); end
    tests++; if (bus_if.rx_busy !== 1'b0) begin fails++; $display("FAIL reset_rx_busy: got %b want 0", bus_if.rx_busy); end
    rst = 1'b0;
    idle(40);
    tests++; if (bus_if.rx_busy !== 1'b0) begin fails++; $display("FAIL idle_rx_busy: got %b want 0", bus_if.rx_busy); end
  endtask

  task automatic test_basic();
    int bv, bf, t0, lat;
    bv = valid_cnt; bf = ferr_cnt;
    t0 = cyc;
    send_frame(8'hA5, 1'b0, 1'b1);
    idle(50);
    lat = vtime[bv] - t0;
    tests++; if (valid_cnt - bv !== 1) begin fails++; $display("FAIL basic_valid_count: got %0d want 1", valid_cnt - bv); end
    tests++; if (vdata[bv] !== 8'hA5) begin fails++; $display("FAIL basic_data: got %h want a5", vdata[bv]); end
    tests++; if (lat < LAT_LO || lat > LAT_HI) begin fails++; $display("FAIL basic_latency: got %0d want %0d..%0d", lat, LAT_LO, LAT_HI); end
    tests++; if (ferr_cnt - bf !== 0) begin fails++; $display("FAIL basic_framing: got %0d want 0", ferr_cnt - bf); end
    tests++; if (bus_if.rx_busy !== 1'b0) begin fails++; $display("FAIL basic_busy_after: got %b want 0", bus_if.rx_busy); end
    tests++; if (bus_if.rx_data !== 8'hA5) begin fails++; $display("FAIL basic_rx_data_held: got %h want a5", bus_if.rx_data); end
  endtask

  task automatic test_glitch();
    int bv, bf;
    bv = valid_cnt; bf = ferr_cnt;
    bus_if.rx = 1'b0;
    repeat (15) @(negedge clk);
    tests++; if (bus_if.rx_busy !== 1'b1) begin fails++; $display("FAIL glitch_busy_during: got %b want 1", bus_if.rx_busy); end
    repeat (15) @(negedge clk);
    idle(300);
    tests++; if (valid_cnt - bv !== 0) begin fails++; $display("FAIL glitch_valid: got %0d want 0", valid_cnt - bv); end
    tests++; if (ferr_cnt - bf !== 0) begin fails++; $display("FAIL glitch_framing: got %0d want 0", ferr_cnt - bf); end
    tests++; if (bus_if.rx_data !== 8'hA5) begin fails++; $display("FAIL glitch_rx_data: got %h want a5", bus_if.rx_data); end
    tests++; if (bus_if.rx_busy !== 1'b0) begin fails++; $display("FAIL glitch_busy_after: got %b want 0", bus_if.rx_busy); end
  endtask

  task automatic test_break();
    int bv, bf;
    bv = valid_cnt; bf = ferr_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (2000 - BIT_CLKS) @(negedge clk);
    tests++; if (bus_if.rx_busy !== 1'b1) begin fails++; $display("FAIL break_busy_held: got %b want 1", bus_if.rx_busy); end
    idle(200);
    tests++; if (ferr_cnt - bf !== 1) begin fails++; $display("FAIL break_framing_count: got %0d want 1", ferr_cnt - bf); end
    tests++; if (valid_cnt - bv !== 0) begin fails++; $display("FAIL break_valid: got %0d want 0", valid_cnt - bv); end
    tests++; if (bus_if.rx_data !== 8'h3C) begin fails++; $display("FAIL break_rx_data: got %h want 3c", bus_if.rx_data); end
    tests++; if (bus_if.rx_busy !== 1'b0) begin fails++; $display("FAIL break_busy_after: got %b want 0", bus_if.rx_busy); end
    send_frame(8'h5A, 1'b0, 1'b1);
    idle(50);
    tests++; if (valid_cnt - bv !== 1) begin fails++; $display("FAIL break_next_valid: got %0d want 1", valid_cnt - bv); end
    tests++; if (vdata[bv] !== 8'h5A) begin fails++; $display("FAIL break_next_data: got %h want 5a", vdata[bv]); end
    tests++; if (ferr_cnt - bf !== 1) begin fails++; $display("FAIL break_next_framing: got %0d want 1", ferr_cnt - bf); end
  endtask

  task automatic test_back_to_back();
    int bv, bf, gap;
    bv = valid_cnt; bf = ferr_cnt;
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    idle(50);
    gap = vtime[bv+1] - vtime[bv];
    tests++; if (valid_cnt - bv !== 2) begin fails++; $display("FAIL b2b_valid_count: got %0d want 2", valid_cnt - bv); end
    tests++; if (vdata[bv] !== 8'h00) begin fails++; $display("FAIL b2b_first_data: got %h want 00", vdata[bv]); end
    tests++; if (vdata[bv+1] !== 8'hFF) begin fails++; $display("FAIL b2b_second_data: got %h want ff", vdata[bv+1]); end
    tests++; if (gap !== FRAME_CLKS) begin fails++; $display("FAIL b2b_spacing: got %0d want %0d", gap, FRAME_CLKS); end
    tests++; if (ferr_cnt - bf !== 0) begin fails++; $display("FAIL b2b_framing: got %0d want 0", ferr_cnt - bf); end
  endtask

  task automatic test_reset_midframe();
    int bv, bf;
    bv = valid_cnt; bf = ferr_cnt;
    // Aborted frame 0xF0: remaining bits are high, so no false start follows
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0);
    bus_if.rx = 1'b1;
    repeat (BIT_CLKS / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++; if (bus_if.rx_busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b want 0", bus_if.rx_busy); end
    tests++; if (bus_if.rx_data !== 8'h00) begin fails++; $display("FAIL midrst_rx_data: got %h want 00", bus_if.rx_data); end
    idle(FRAME_CLKS);
    send_frame(8'h81, 1'b0, 1'b1);
    idle(50);
    tests++; if (valid_cnt - bv !== 1) begin fails++; $display("FAIL midrst_valid_count: got %0d want 1", valid_cnt - bv); end
    tests++; if (vdata[bv] !== 8'h81) begin fails++; $display("FAIL midrst_data: got %h want 81", vdata[bv]); end
    tests++; if (ferr_cnt - bf !== 0) begin fails++; $display("FAIL midrst_framing: got %0d want 0", ferr_cnt - bf); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int bv, bp, bc;
    bv = valid_cnt; bp = perr_cnt; bc = perr_coinc;
    send_frame(8'h07, 1'b0, 1'b1);
    idle(50);
    tests++; if (valid_cnt - bv !== 1) begin fails++; $display("FAIL parity_good_valid: got %0d want 1", valid_cnt - bv); end
    tests++; if (perr_cnt - bp !== 0) begin fails++; $display("FAIL parity_good_error: got %0d want 0", perr_cnt - bp); end
    send_frame(8'h07, 1'b1, 1'b1);
    idle(50);
    tests++; if (valid_cnt - bv !== 2) begin fails++; $display("FAIL parity_bad_valid: got %0d want 2", valid_cnt - bv); end
    tests++; if (perr_cnt - bp !== 1) begin fails++; $display("FAIL parity_bad_error: got %0d want 1", perr_cnt - bp); end
    tests++; if (perr_coinc - bc !== 1) begin fails++; $display("FAIL parity_coincident: got %0d want 1", perr_coinc - bc); end
    tests++; if (vdata[bv+1] !== 8'h07) begin fails++; $display("FAIL parity_bad_data: got %h want 07", vdata[bv+1]); end
  endtask
`endif

  initial begin
    bus_if.rx = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_glitch();
    test_break();
    test_back_to_back();
    test_reset_midframe();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- UART receive engine; sits directly downstream of the team's baud generator and consumes its 16x oversample strobe.
- Synchronises the asynchronous serial line, then detects and validates the start bit.
- Samples each bit at mid-period, deserialises LSB-first, checks the stop bit and presents a parallel byte with a one-cycle valid strobe.

Parameters:
- DATA_BITS, 8, number of data bits per frame (5..8 legal).
- SYNC_STAGES, 2, flops in the rx input synchroniser (2..3 legal).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- baud_tick_16x  input  1  one-clk strobe at 16x baud rate, from the baud generator.
- rx  input  1  asynchronous serial line; idle high.
- rx_data  output  DATA_BITS  last received data word, LSB = first bit on the wire.
- rx_valid  output  1  one-clk pulse when rx_data is updated by a good frame.
- framing_error  output  1  one-clk pulse when the stop bit is sampled low.
- rx_busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - Synchroniser flops = 1; state = IDLE; tick_cnt = 0; bit_cnt = 0; shift register = 0.
  - rx_data = 0; rx_valid = 0; framing_error = 0; rx_busy = 0.
  - Reset mid-frame abandons the frame with no pulse output.
- rxs denotes the synchronised rx (last synchroniser stage). All decisions use rxs, evaluated only on clk edges where baud_tick_16x=1; all counters advance only on ticks.
- States: IDLE, START, DATA, STOP, BREAK_WAIT.
- IDLE: on a tick with rxs=0, go to START with tick_cnt=0.
- START:
  - Each tick, tick_cnt++.
  - On the tick where tick_cnt==7 (mid start bit): if rxs=0, go to DATA with tick_cnt=0 and bit_cnt=0; else (glitch) return to IDLE silently.
- DATA:
  - Each tick, tick_cnt++.
  - On the tick where tick_cnt==15: shift rxs into the MSB of the shift register (right-shift, so the first bit ends at LSB), tick_cnt=0, bit_cnt++.
  - After the DATA_BITS-th sample, go to STOP.
- STOP:
  - On the tick where tick_cnt==15, rx_data is loaded from the shift register in every case.
  - If rxs=1: pulse rx_valid, go to IDLE.
  - If rxs=0: pulse framing_error, go to BREAK_WAIT.
- BREAK_WAIT: stay until a tick with rxs=1, then go to IDLE. A held-low line (break) produces exactly one framing_error.
- Output timing:
  - rx_valid and framing_error are registered and high for exactly one clk, the cycle after the stop-sample edge.
  - rx_data changes on the same edge those pulses assert and is held until the next frame completes.
- The return to IDLE happens at the stop mid-sample, so a start edge arriving half a bit later is accepted (back-to-back frames with no gap).
- Ticks: baud_tick_16x asserted on consecutive clks is legal; each cycle counts as one tick. rx changes between ticks are ignored.
- Counters:
  - tick_cnt is 4 bits and wraps only via explicit clear.
  - bit_cnt is $clog2(DATA_BITS+1) bits.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds state PARITY between DATA and STOP, sampled at tick_cnt==15.
  - Adds parameter ODD_PARITY (default 0 = even) and output port parity_error (1 bit).
  - parity_error is a one-clk pulse coincident with the stop-sample result when XOR(data bits, parity bit) != ODD_PARITY.
  - rx_valid still pulses on a good stop; software discards the word on parity_error.
  - parity_error resets to 0.
- Undefined: no PARITY state, no ODD_PARITY parameter, no parity_error port; the frame is start + DATA_BITS + stop.

Test Plan:
- Tick every 10 clks (1.536 MHz / 9600 / 16); bit period = 160 clks. Send 0xA5, 8N1 -> one rx_valid pulse, rx_data=0xA5, framing_error never asserted, rx_busy low afterwards.
- Low pulse on rx lasting 30 clks (3 ticks), then high -> returns to IDLE; no rx_valid, no framing_error, rx_data unchanged.
- Send 0x3C with stop bit driven 0, line held low 2000 clks, then high -> exactly one framing_error pulse, rx_data=0x3C, no rx_valid; next frame 0x5A is received correctly only after rx returns high.
- Back-to-back 0x00 then 0xFF with zero idle gap -> two rx_valid pulses, 1600 clks apart, with data 0x00 then 0xFF.
- Assert rst for one clk during data bit 4 of a frame, then send 0x81 -> no pulse for the aborted frame; 0x81 received cleanly.
- With UART_RX_PARITY_EN, even parity: send 0x07 with parity 1 -> rx_valid, parity_error=0. Send 0x07 with parity 0 -> rx_valid and parity_error pulse in the same cycle.
